// File: rtl/led_matrix_pkg.sv
// Shared types, constants and the snake-order address map for the LED matrix link.
package led_matrix_pkg;

  localparam int         START_BITS = 32;
  localparam int         FRAME_W    = 32;
  localparam logic [2:0] LED_HDR    = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH,
    PIXEL,
    END,
    DONE
  } state_t;

  // Chain position -> raster index: even rows run right-to-left, odd rows left-to-right.
  function automatic logic [5:0] snake_map(input logic [6:0] p, input int row_len);
    int r;
    int c;
    int a;
    r = int'(p) / row_len;
    c = int'(p) % row_len;
    a = (r % 2 == 0) ? (r * row_len + (row_len - 1 - c)) : int'(p);
    return a[5:0];
  endfunction

endpackage

// File: rtl/led_shift_engine.sv
// Serialiser for the matrix link: CLK_DIV divider plus a 32-bit MSB-first shifter
// that keeps emitting zeros once the loaded word is exhausted (used for long end frames).
module led_shift_engine #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [6:0]  nbits,
  output logic        led_clk,
  output logic        led_data,
  output logic        done
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic [31:0]      shreg;
  logic [5:0]       bits_left;
  logic [DIV_W-1:0] div_cnt;
  logic             phase_end;

  assign phase_end = (div_cnt == DIV_LAST);
  // Marks the last cycle of the final high phase, so a back-to-back load adds no gap.
  assign done = active && led_clk && phase_end && (bits_left == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
      div_cnt   <= '0;
      led_clk   <= 1'b0;
      led_data  <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      active    <= 1'b1;
      led_clk   <= 1'b0;
      led_data  <= word[31];
      shreg     <= {word[30:0], 1'b0};
      bits_left <= 6'(nbits - 7'd1);
      div_cnt   <= '0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!led_clk) begin
          led_clk <= 1'b1;
        end else if (bits_left == '0) begin
          active  <= 1'b0;
          led_clk <= 1'b0;
        end else begin
          led_clk   <= 1'b0;
          led_data  <= shreg[31];
          shreg     <= {shreg[30:0], 1'b0};
          bits_left <= bits_left - 6'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame controller for the APA102-style matrix: start frame, one fetched word per LED
// in snake order, zero end frame; one-shot or free-running refresh scheduling.
module led_frame_sequencer
  import led_matrix_pkg::*;
#(
  parameter int NUM_LEDS = 64,
  parameter int ROW_LEN  = 8,
  parameter int CLK_DIV  = 1,
  parameter int END_BITS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        repeat_en,
  input  logic [4:0]  brightness,
  output logic        pix_req,
  output logic [5:0]  pix_addr,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        led_clk,
  output logic        led_data,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [6:0] LAST_LED = 7'(NUM_LEDS - 1);

  state_t      state;
  logic [6:0]  p;
  logic [4:0]  bright_q;
  logic        sh_load;
  logic [31:0] sh_word;
  logic [6:0]  sh_bits;
  logic        sh_done;

  // Loads coincide with the transition so the first bit of each segment starts next cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    sh_load = 1'b0;
    sh_word = '0;
    sh_bits = 7'(START_BITS);
    case (state)
      IDLE:  sh_load = start;
      FETCH: if (pix_req && pix_valid) begin
        sh_load = 1'b1;
        sh_word = {LED_HDR, bright_q, pix_data};
        sh_bits = 7'(FRAME_W);
      end
      PIXEL: if (sh_done && p == LAST_LED) begin
        sh_load = 1'b1;
        sh_bits = 7'(END_BITS);
      end
      DONE:  sh_load = repeat_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      p          <= '0;
      bright_q   <= '0;
      pix_req    <= 1'b0;
      pix_addr   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bright_q <= brightness;
          busy     <= 1'b1;
          state    <= START;
        end
        START: if (sh_done) begin
          p        <= '0;
          pix_req  <= 1'b1;
          pix_addr <= snake_map(7'd0, ROW_LEN);
          state    <= FETCH;
        end
        FETCH: if (pix_valid) begin
          pix_req <= 1'b0;
          state   <= PIXEL;
        end
        PIXEL: if (sh_done) begin
          if (p == LAST_LED) begin
            state <= END;
          end else begin
            p        <= p + 7'd1;
            pix_req  <= 1'b1;
            pix_addr <= snake_map(p + 7'd1, ROW_LEN);
            state    <= FETCH;
          end
        end
        END: if (sh_done) begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= DONE;
        end
        DONE: if (repeat_en) begin
          bright_q <= brightness;
          busy     <= 1'b1;
          state    <= START;
        end else begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  led_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .word     (sh_word),
    .nbits    (sh_bits),
    .led_clk  (led_clk),
    .led_data (led_data),
    .done     (sh_done)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench: expected serial bits are queued as frames start and pixels are
// supplied, then popped on every led_clk rising edge.
module tb_led_frame_sequencer;

  localparam int NUM_LEDS   = 64;
  localparam int ROW_LEN    = 8;
  localparam int CLK_DIV    = 1;
  localparam int END_BITS   = 64;
  localparam int FRAME_BITS = 32 + 32 * NUM_LEDS + END_BITS;
  localparam int FRAME_CYC  = 2 * CLK_DIV * FRAME_BITS + NUM_LEDS + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        repeat_en;
  logic [4:0]  brightness;
  logic        pix_req;
  logic [5:0]  pix_addr;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data  = '0;
  logic        led_clk;
  logic        led_data;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  int done_count = 0;
  int k = 0;
  int stall_cnt = 0;
  int stall_led = -1;
  int stall_len = 0;
  bit data_mode = 1'b0;

  bit         exp_bits[$];
  logic [4:0] frame_bright = '0;
  logic [4:0] bright_prev = '0;
  logic       busy_prev = 1'b0;
  logic       led_clk_prev = 1'b0;

  led_frame_sequencer #(
    .NUM_LEDS (NUM_LEDS),
    .ROW_LEN  (ROW_LEN),
    .CLK_DIV  (CLK_DIV),
    .END_BITS (END_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .repeat_en  (repeat_en),
    .brightness (brightness),
    .pix_req    (pix_req),
    .pix_addr   (pix_addr),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .led_clk    (led_clk),
    .led_data   (led_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_addr(input int pos);
    int r;
    int c;
    int a;
    r = pos / ROW_LEN;
    c = pos % ROW_LEN;
    a = (r % 2 == 0) ? (r * ROW_LEN + ROW_LEN - 1 - c) : pos;
    return 6'(a);
  endfunction

  function automatic logic [23:0] pattern(input int idx);
    logic [7:0] kk;
    kk = 8'(idx);
    return {kk * 8'd5 + 8'd1, kk ^ 8'hA5, 8'd200 - kk};
  endfunction

  // Scoreboard, pixel source and edge monitor share one process so queue order is fixed.
  always @(negedge clk) begin
    logic [23:0] d;
    logic [31:0] w;
    bit          b;
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      frame_bright = bright_prev;
      repeat (32) exp_bits.push_back(1'b0);
    end
    if (led_clk === 1'b1 && led_clk_prev === 1'b0) begin
      rises++;
      checks++;
      assert (exp_bits.size() > 0) else begin
        errors++;
        $error("FAIL spurious_led_clk_rise: observed rise #%0d at cycle %0d, required no edge", rises, cyc);
      end
      if (exp_bits.size() > 0) begin
        b = exp_bits.pop_front();
        check($sformatf("led_data_rise%0d", rises), 64'(led_data), 64'(b));
      end
    end
    if (frame_done === 1'b1) done_count++;
    if (reset === 1'b1) begin
      exp_bits.delete();
      k = 0;
      stall_cnt = 0;
      pix_valid = 1'b0;
    end else if (pix_req === 1'b1) begin
      if (k == stall_led && stall_cnt < stall_len) begin
        check("stall_pix_addr", 64'(pix_addr), 64'(exp_addr(k)));
        check("stall_led_clk", 64'(led_clk), 64'd0);
        pix_valid = 1'b0;
        stall_cnt++;
      end else begin
        check($sformatf("pix_addr_p%0d", k), 64'(pix_addr), 64'(exp_addr(k)));
        d = data_mode ? pattern(k) : 24'h000F00;
        pix_data  = d;
        pix_valid = 1'b1;
        w = {3'b111, frame_bright, d};
        for (int i = 31; i >= 0; i--) exp_bits.push_back(w[i]);
        if (k == NUM_LEDS - 1) repeat (END_BITS) exp_bits.push_back(1'b0);
        stall_cnt = 0;
        k = (k + 1) % NUM_LEDS;
      end
    end else begin
      pix_valid = 1'b0;
    end
    busy_prev    = busy;
    led_clk_prev = led_clk;
    bright_prev  = brightness;
  end

  task automatic check_idle(input string tag);
    check({tag, "_led_clk"},    64'(led_clk),    64'd0);
    check({tag, "_led_data"},   64'(led_data),   64'd0);
    check({tag, "_pix_req"},    64'(pix_req),    64'd0);
    check({tag, "_pix_addr"},   64'(pix_addr),   64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  task automatic start_frame(input logic [4:0] b, output int c0);
    brightness = b;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("cycle1_busy", 64'(busy), 64'd1);
    check("cycle1_led_clk", 64'(led_clk), 64'd0);
    repeat (CLK_DIV) @(negedge clk);
    check("first_rise_led_clk", 64'(led_clk), 64'd1);
  endtask

  task automatic wait_done(input int limit, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL frame_done_timeout: observed no pulse in %0d cycles, required one", limit);
    end
  endtask

  initial begin
    int c0;
    int c1;
    int c2;
    int r0;
    reset = 1'b1;
    start = 1'b1;
    repeat_en = 1'b0;
    brightness = 5'd0;

    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Single frame, constant colour, zero-wait source.
    data_mode = 1'b0;
    r0 = rises;
    start_frame(5'd16, c0);
    wait_done(3 * FRAME_CYC, c1);
    check("single_frame_cycles", 64'(c1 - c0), 64'(FRAME_CYC));
    check("single_frame_rises", 64'(rises - r0), 64'(FRAME_BITS));
    check("done_cycle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("after_done_busy", 64'(busy), 64'd0);
    check("after_done_pix_req", 64'(pix_req), 64'd0);
    check("after_done_queue_left", 64'(exp_bits.size()), 64'd0);
    check("single_frame_done_count", 64'(done_count), 64'd1);

    // LED 3 source stalls five cycles; stream must match, frame just runs longer.
    data_mode = 1'b1;
    stall_led = 3;
    stall_len = 5;
    r0 = rises;
    start_frame(5'd5, c0);
    wait_done(3 * FRAME_CYC, c1);
    check("stall_frame_cycles", 64'(c1 - c0), 64'(FRAME_CYC + 5));
    check("stall_frame_rises", 64'(rises - r0), 64'(FRAME_BITS));
    stall_led = -1;
    stall_len = 0;
    repeat (4) @(negedge clk);

    // Free-running: two frames; brightness change mid-frame lands only in frame two.
    repeat_en = 1'b1;
    start_frame(5'd7, c0);
    repeat (1000) @(negedge clk);
    brightness = 5'd31;
    wait_done(3 * FRAME_CYC, c1);
    @(negedge clk);
    repeat_en = 1'b0;
    check("repeat_first_cycles", 64'(c1 - c0), 64'(FRAME_CYC));
    wait_done(3 * FRAME_CYC, c2);
    check("repeat_done_spacing", 64'(c2 - c1), 64'(FRAME_CYC));
    repeat (20) @(negedge clk);
    check("repeat_stop_busy", 64'(busy), 64'd0);
    check("repeat_done_count", 64'(done_count), 64'd4);

    // Start while busy must be ignored; reset during LED 10 aborts cleanly.
    start_frame(5'd9, c0);
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && k < 11; i++) @(negedge clk);
    checks++;
    assert (k >= 11) else begin
      errors++;
      $error("FAIL reach_led10: observed %0d pixels supplied, required 11", k);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("midframe_reset");
    reset = 1'b0;
    r0 = rises;
    repeat (300) @(negedge clk);
    check("after_abort_rises", 64'(rises - r0), 64'd0);
    check("after_abort_busy", 64'(busy), 64'd0);
    check("after_abort_done_count", 64'(done_count), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
